// File: rtl/mem_periph_pkg.sv
// Shared CPU definitions: pipeline stage bundles and the peripheral register map.
package mem_periph_pkg;

   // EX/MEM and MEM/WB stage bundles seen by the memory-stage peripherals
   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] alu_out;
      logic [31:0] wdata;
   } ex2mem_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [31:0] alu_out;
   } mem2wb_t;

   // Peripheral window base and byte offsets within it
   localparam logic [31:0] PeriphBase = 32'h4000_0000;
   localparam logic [7:0]  OffTh      = 8'h00;
   localparam logic [7:0]  OffTl      = 8'h04;
   localparam logic [7:0]  OffTcon    = 8'h08;
   localparam logic [7:0]  OffLed     = 8'h0C;
   localparam logic [7:0]  OffSwitch  = 8'h10;
   localparam logic [7:0]  OffDigi    = 8'h14;
   localparam logic [7:0]  OffSystick = 8'h18;

   // TCON bit positions
   localparam int unsigned TconTe = 0;  // timer enable
   localparam int unsigned TconIe = 1;  // interrupt enable
   localparam int unsigned TconIs = 2;  // interrupt status, sticky

   typedef enum logic [2:0] {
      SelNone,
      SelTh,
      SelTl,
      SelTcon,
      SelLed,
      SelSwitch,
      SelDigi,
      SelSystick
   } periph_sel_e;

endpackage

// File: rtl/periph_timer.sv
// Reloading 32-bit timer: TH reload value, TL counter, TCON control/status.
module periph_timer
   import mem_periph_pkg::*;
#(
   parameter bit TIMER_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_th,
   input  logic        wr_tl,
   input  logic        wr_tcon,
   input  logic [31:0] wdata,
   output logic [31:0] th,
   output logic [31:0] tl,
   output logic [2:0]  tcon,
   output logic        irqout
);

   logic [31:0] th_q, tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;

   // Count/reload, with CPU writes overriding the hardware update
   always_comb begin
      tl_d   = tl_q;
      tcon_d = tcon_q;
      // A TL write on the overflow edge cancels the reload and its status set
      if (TIMER_EN && tcon_q[TconTe] && !wr_tl) begin
         if (tl_q == 32'hFFFF_FFFF) begin
            tl_d = th_q;
            if (tcon_q[TconIe]) begin
               tcon_d[TconIs] = 1'b1;
            end
         end else begin
            tl_d = tl_q + 32'd1;
         end
      end
      if (wr_tl) begin
         tl_d = wdata;
      end
      if (wr_tcon) begin
         tcon_d = wdata[2:0];
      end
   end

   // Timer state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         th_q   <= '0;
         tl_q   <= '0;
         tcon_q <= '0;
      end else begin
         if (wr_th) begin
            th_q <= wdata;
         end
         tl_q   <= tl_d;
         tcon_q <= tcon_d;
      end
   end

   assign th     = th_q;
   assign tl     = tl_q;
   assign tcon   = tcon_q;
   assign irqout = tcon_q[TconIe] & tcon_q[TconIs];

endmodule

// File: rtl/mem_periph.sv
// MEM-stage peripheral block: address decode, LED/DIGI/SYSTICK, switch sync, timer.
module mem_periph
   import mem_periph_pkg::*;
#(
   parameter bit TIMER_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [7:0]  switch,
   output logic [31:0] rdata,
   output logic [7:0]  led,
   output logic [11:0] digi,
   output logic        irqout
);

   periph_sel_e sel;
   logic [7:0]  word_off;
   logic        unused_addr;
   logic [7:0]  led_q, sw_meta_q, sw_sync_q;
   logic [11:0] digi_q;
   logic [31:0] systick_q;
   logic [31:0] th, tl;
   logic [2:0]  tcon;

   // Byte lanes are ignored: every access is a full word
   assign unused_addr = ^addr[1:0];

   // Word-address decode of the peripheral window
   always_comb begin
      sel      = SelNone;
      word_off = {addr[7:2], 2'b00};
      if (addr[31:8] == PeriphBase[31:8]) begin
         case (word_off)
            OffTh:      sel = SelTh;
            OffTl:      sel = SelTl;
            OffTcon:    sel = SelTcon;
            OffLed:     sel = SelLed;
            OffSwitch:  sel = SelSwitch;
            OffDigi:    sel = SelDigi;
            OffSystick: sel = SelSystick;
            default:    sel = SelNone;
         endcase
      end
   end

   // LED, DIGI, free-running SYSTICK and the switch synchronizer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q     <= '0;
         digi_q    <= '0;
         systick_q <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         systick_q <= systick_q + 32'd1;
         sw_meta_q <= switch;
         sw_sync_q <= sw_meta_q;
         if (wr && sel == SelLed) begin
            led_q <= wdata[7:0];
         end
         if (wr && sel == SelDigi) begin
            digi_q <= wdata[11:0];
         end
      end
   end

   // Zero-latency read mux; reflects pre-write values during a write cycle
   always_comb begin
      rdata = '0;
      if (rd) begin
         case (sel)
            SelTh:      rdata = th;
            SelTl:      rdata = tl;
            SelTcon:    rdata = {29'd0, tcon};
            SelLed:     rdata = {24'd0, led_q};
            SelSwitch:  rdata = {24'd0, sw_sync_q};
            SelDigi:    rdata = {20'd0, digi_q};
            SelSystick: rdata = systick_q;
            default:    rdata = '0;
         endcase
      end
   end

   periph_timer #(
      .TIMER_EN (TIMER_EN)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .wr_th   (wr && sel == SelTh),
      .wr_tl   (wr && sel == SelTl),
      .wr_tcon (wr && sel == SelTcon),
      .wdata   (wdata),
      .th      (th),
      .tl      (tl),
      .tcon    (tcon),
      .irqout  (irqout)
   );

   assign led  = led_q;
   assign digi = digi_q;

endmodule

// File: doc/mem_periph.md
MEM_PERIPH -- requirements
Module: mem_periph

Interface
REQ-001 The module SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd  in  1  MEM-stage load strobe.
- wr  in  1  MEM-stage store strobe.
- addr  in  32  byte address from the EX/MEM ALU result.
- wdata  in  32  store data.
- switch  in  8  board switch inputs.
- rdata  out  32  load data, feeding the MEM/WB data input.
- led  out  8  LED register.
- digi  out  12  seven-segment drive register.
- irqout  out  1  timer interrupt request to the PC/control logic.
REQ-002 The module SHALL have one parameter, TIMER_EN, default 1, meaning the timer is present; when 0, TL is held constant.

Function
REQ-003 The module SHALL decode addr[31:2] only; addr[1:0] SHALL be ignored, so all accesses are word accesses.
REQ-004 The register map SHALL be (base 0x40000000): +0x00 TH (rw, 32 bits); +0x04 TL (rw, 32 bits); +0x08 TCON (rw, bits [2:0]); +0x0C LED (rw, 8 bits); +0x10 SWITCH (ro, 8 bits); +0x14 DIGI (rw, 12 bits); +0x18 SYSTICK (ro, 32 bits).
REQ-005 Reads SHALL be combinational, with zero cycles of latency: rdata = selected register, zero-extended, when rd=1 and the address is mapped; otherwise rdata = 0.
REQ-006 Writes SHALL take effect on the rising edge where wr=1; writes to read-only or unmapped addresses SHALL be ignored.
REQ-007 When rd=1 and wr=1 together, rdata SHALL show the pre-write value, and the write SHALL commit at the edge.
REQ-008 TCON fields: bit 0 = timer enable; bit 1 = interrupt enable; bit 2 = interrupt status (sticky).
REQ-009 Timer operation, when TCON[0]=1 and TIMER_EN=1:
- If TL /= 0xFFFFFFFF, TL SHALL increment by 1 each cycle.
- If TL = 0xFFFFFFFF, TL SHALL reload from TH on the next edge.
- On that reload edge, if TCON[1]=1, TCON[2] SHALL be set.
REQ-010 When TCON[0]=0, TL SHALL hold its value.
REQ-011 A CPU write to TL SHALL take priority over increment and reload on the same edge.
REQ-012 A CPU write to TCON SHALL take priority over the hardware set of TCON[2] on the same edge; software clears the status by writing 0 to bit 2.
REQ-013 irqout SHALL equal TCON[1] AND TCON[2], and SHALL remain asserted until software clears the status.
REQ-014 SYSTICK SHALL increment every cycle, independent of TCON, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-015 The SWITCH read value SHALL be the switch input sampled through a 2-flop synchronizer, giving 2 cycles of latency.
REQ-016 led and digi SHALL be driven directly from their registers.

Reset
REQ-017 When rst=0, every register SHALL be cleared asynchronously: TH, TL, TCON, LED, DIGI, SYSTICK and the synchronizer flops all = 0. As a result, led=0, digi=0 and irqout=0.
REQ-018 A reset asserted mid-count SHALL abort the count; the timer SHALL stay stopped after release until software sets TCON[0].
REQ-019 rdata SHALL stay combinational during reset and SHALL return the reset register values.

Structure
REQ-020 Register offsets, the base address and TCON bit indices SHALL be defined as constants in the shared CPU package, alongside the MEM2WB/EX2MEM definitions.
REQ-021 The timer (TH/TL/TCON plus reload logic) SHALL be a single sub-module named periph_timer; decode, LED, DIGI, SYSTICK and the synchronizer SHALL stay in mem_periph.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset check: pulse rst low mid-run -> all outputs 0 immediately; SYSTICK read = 0 after release.
- Reload and interrupt: write TH=0xFFFFFFF0, TL=0xFFFFFFFD, TCON=3 -> TL reaches 0xFFFFFFFF after 2 cycles; TL=0xFFFFFFF0 the next cycle, with TCON=7 and irqout=1 in that same cycle.
- Interrupt clear and priority: with irqout=1, write TCON=3 -> irqout=0 after the edge. A TL write coinciding with overflow -> TL = the written value, and no status set.
- LED/DIGI access: write LED=0xA5 at addr 0x4000000E -> led=0xA5, and a read returns 0x000000A5. Write DIGI=0xFFF -> digi=0xFFF.
- Switch and unmapped access: switch=0x3C -> SWITCH read = 0x3C from the 2nd edge onward. A write to SWITCH does not change it. A read of 0x40000020 returns 0, and a write there changes nothing.
- Read-during-write: rd=1, wr=1 to TL with wdata=5 -> rdata shows the old TL; TL=5 after the edge.
